// File: rtl/pixel_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scan_sequencer
// Purpose  : Walks a rows x cols pixel window; per pixel it handshakes pixel
//            select, waits the settle time, fires one ADC capture and waits.
// Revision : 1.0  initial release
// ============================================================================
module pixel_scan_sequencer #(
    parameter int MAX_DIM = 112
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       frame_abort,
    input  logic [7:0] num_rows,
    input  logic [7:0] num_cols,
    input  logic [7:0] settle_counts,
    input  logic       pixel_ack,
    input  logic       adc_capture_done,
    output logic       pixel_req,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       adc_capture_start,
    output logic       newline_sample,
    output logic       frame_done,
    output logic       busy
);

    localparam int         CW        = $clog2(MAX_DIM);
    localparam logic [7:0] C_MAX_DIM = 8'(MAX_DIM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_row, r_col, r_row_last, r_col_last;
    logic [CW-1:0] w_row_nxt, w_col_nxt, w_row_last_nxt, w_col_last_nxt;
    logic [7:0]    r_settle, r_cnt, w_settle_nxt, w_cnt_nxt;
    logic [7:0]    w_rows_clamped, w_cols_clamped;
    logic          w_cap_entry;

    always_comb begin
        w_rows_clamped = (num_rows == 8'd0 || num_rows > C_MAX_DIM) ? C_MAX_DIM : num_rows;
        w_cols_clamped = (num_cols == 8'd0 || num_cols > C_MAX_DIM) ? C_MAX_DIM : num_cols;

        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_row_last_nxt = r_row_last;
        w_col_last_nxt = r_col_last;
        w_settle_nxt   = r_settle;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nxt    = S_SELECT;
                    w_row_last_nxt = CW'(w_rows_clamped - 8'd1);
                    w_col_last_nxt = CW'(w_cols_clamped - 8'd1);
                    w_settle_nxt   = settle_counts;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                end
            end
            S_SELECT: begin
                if (pixel_ack) begin
                    if (r_settle == 8'd0) begin
                        w_state_nxt = S_CAPTURE;
                    end else begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = r_settle;
                    end
                end
            end
            S_SETTLE: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_CAPTURE: begin
                // A done coincident with our own start pulse belongs to a prior conversion.
                if (adc_capture_done && !adc_capture_start) begin
                    w_state_nxt = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (r_col < r_col_last) begin
                    w_col_nxt   = r_col + 1'b1;
                    w_state_nxt = S_SELECT;
                end else if (r_row < r_row_last) begin
                    w_col_nxt   = '0;
                    w_row_nxt   = r_row + 1'b1;
                    w_state_nxt = S_SELECT;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (frame_abort) begin
            w_state_nxt = S_IDLE;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
        end

        w_cap_entry = (w_state_nxt == S_CAPTURE) && (r_state != S_CAPTURE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_row             <= '0;
            r_col             <= '0;
            r_row_last        <= '0;
            r_col_last        <= '0;
            r_settle          <= 8'd0;
            r_cnt             <= 8'd0;
            pixel_req         <= 1'b0;
            adc_capture_start <= 1'b0;
            newline_sample    <= 1'b0;
            frame_done        <= 1'b0;
            busy              <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_row             <= w_row_nxt;
            r_col             <= w_col_nxt;
            r_row_last        <= w_row_last_nxt;
            r_col_last        <= w_col_last_nxt;
            r_settle          <= w_settle_nxt;
            r_cnt             <= w_cnt_nxt;
            pixel_req         <= (w_state_nxt == S_SELECT);
            adc_capture_start <= w_cap_entry;
            newline_sample    <= w_cap_entry && (w_col_nxt == '0);
            frame_done        <= (w_state_nxt == S_DONE);
            busy              <= (w_state_nxt != S_IDLE);
        end
    end

    assign row = 8'(r_row);
    assign col = 8'(r_col);

endmodule
`default_nettype wire

// File: tb/tb_pixel_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_scan_sequencer
// Purpose  : Self-checking bench; frames are predicted from the raster-order
//            rules and handshake latencies, then compared cycle by cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_abort = 1'b0;
    logic [7:0] num_rows = 8'd0;
    logic [7:0] num_cols = 8'd0;
    logic [7:0] settle_counts = 8'd0;
    logic       pixel_ack = 1'b0;
    logic       adc_capture_done = 1'b0;
    logic       pixel_req;
    logic [7:0] row;
    logic [7:0] col;
    logic       adc_capture_start;
    logic       newline_sample;
    logic       frame_done;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    pixel_scan_sequencer #(.MAX_DIM(112)) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_start       (frame_start),
        .frame_abort       (frame_abort),
        .num_rows          (num_rows),
        .num_cols          (num_cols),
        .settle_counts     (settle_counts),
        .pixel_ack         (pixel_ack),
        .adc_capture_done  (adc_capture_done),
        .pixel_req         (pixel_req),
        .row               (row),
        .col               (col),
        .adc_capture_start (adc_capture_start),
        .newline_sample    (newline_sample),
        .frame_done        (frame_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int clampd(input int n);
        return (n == 0 || n > 112) ? 112 : n;
    endfunction

    // Runs one frame; the pixel-select and ADC responders are modelled inline.
    // abort_idx >= 0 aborts in the settle phase of that pixel (needs st >= 1).
    task automatic run_frame(input int nr, input int nc, input int st, input int ack_dly,
                             input int done_lat, input int abort_idx,
                             input bit hold_done, input bit spam);
        int er, ec, total, idx, cyc, ack_cyc, done_cyc, last_done, budget;
        bit fin;
        er        = clampd(nr);
        ec        = clampd(nc);
        total     = er * ec;
        idx       = 0;
        ack_cyc   = -10;
        done_cyc  = -10;
        last_done = -10;
        fin       = 1'b0;
        budget    = total * (st + ack_dly + done_lat + 6) + 40;

        @(negedge clk);
        check_eq("idle_busy", int'(busy), 0);
        num_rows      = 8'(nr);
        num_cols      = 8'(nc);
        settle_counts = 8'(st);
        frame_start   = 1'b1;
        cyc           = -1;

        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            frame_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            frame_abort = 1'b0;
            if (cyc == 0) begin
                check_eq("start_busy", int'(busy), 1);
                check_eq("start_req", int'(pixel_req), 1);
                check_eq("start_row", int'(row), 0);
                check_eq("start_col", int'(col), 0);
            end
            if (cyc == ack_cyc + 1)
                check_eq("req_fall", int'(pixel_req), 0);
            if (pixel_req && ack_cyc < cyc)
                ack_cyc = cyc + ack_dly;

            if (adc_capture_start) begin
                if (idx >= total)
                    check_eq("extra_capture", idx + 1, total);
                check_eq("cap_row", int'(row), idx / ec);
                check_eq("cap_col", int'(col), idx % ec);
                check_eq("cap_newline", int'(newline_sample), int'(idx % ec == 0));
                check_eq("cap_latency", cyc - ack_cyc, st + 1);
                idx++;
                done_cyc  = cyc + done_lat;
                last_done = hold_done ? cyc + 1 : done_cyc;
            end else begin
                check_eq("newline_alone", int'(newline_sample), 0);
            end

            if (frame_done) begin
                check_eq("done_count", idx, total);
                check_eq("done_latency", cyc - last_done, 2);
                fin = 1'b1;
            end

            if (abort_idx >= 0 && idx == abort_idx && cyc == ack_cyc + 1) begin
                frame_abort      = 1'b1;
                frame_start      = 1'b0;
                pixel_ack        = 1'b0;
                adc_capture_done = 1'b0;
                @(negedge clk);
                frame_abort = 1'b0;
                check_eq("abort_busy", int'(busy), 0);
                check_eq("abort_req", int'(pixel_req), 0);
                check_eq("abort_row", int'(row), 0);
                check_eq("abort_col", int'(col), 0);
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    check_eq("abort_no_cap", int'(adc_capture_start), 0);
                    check_eq("abort_no_done", int'(frame_done), 0);
                end
                fin = 1'b1;
            end else begin
                pixel_ack        = (cyc == ack_cyc);
                adc_capture_done = hold_done || (cyc == done_cyc);
            end
        end
        if (!fin)
            check_eq("frame_timeout", 0, 1);
        frame_start      = 1'b0;
        frame_abort      = 1'b0;
        pixel_ack        = 1'b0;
        adc_capture_done = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int rr, cc, ss, aa, dd;
        bit seen;

        // Reset state
        @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_req", int'(pixel_req), 0);
        check_eq("rst_cap", int'(adc_capture_start), 0);
        check_eq("rst_done", int'(frame_done), 0);
        check_eq("rst_rowcol", int'({row, col}), 0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("idle_after_rst", int'(busy), 0);

        // Nominal 2x3, settle 4, ack 1 cycle after req, done 10 after start
        run_frame(2, 3, 4, 1, 10, -1, 1'b0, 1'b0);

        // Abort while settling at pixel (0,5) of 4x8, then a clean restart
        run_frame(4, 8, 4, 1, 3, 5, 1'b0, 1'b0);
        run_frame(1, 3, 1, 0, 2, -1, 1'b0, 1'b0);

        // Repeated frame_start during a 1x2 frame, then an immediate new frame
        run_frame(1, 2, 2, 1, 2, -1, 1'b0, 1'b1);
        run_frame(2, 2, 0, 0, 1, -1, 1'b0, 1'b0);

        // adc_capture_done held high
        run_frame(2, 3, 1, 0, 1, -1, 1'b1, 1'b0);
        run_frame(1, 2, 0, 2, 1, -1, 1'b1, 1'b0);

        // frame_start together with frame_abort in IDLE
        @(negedge clk);
        frame_start = 1'b1;
        frame_abort = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        frame_abort = 1'b0;
        check_eq("start_abort_busy", int'(busy), 0);
        check_eq("start_abort_req", int'(pixel_req), 0);

        // Clamp of an over-range column count
        run_frame(1, 200, 0, 0, 1, -1, 1'b0, 1'b0);

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            rr = $urandom_range(1, 4);
            cc = $urandom_range(1, 5);
            ss = $urandom_range(0, 5);
            aa = $urandom_range(0, 3);
            dd = $urandom_range(1, 6);
            run_frame(rr, cc, ss, aa, dd, -1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        // Full 112x112 frame from zero counts, no settle
        run_frame(0, 0, 0, 0, 1, -1, 1'b0, 1'b0);

        // Asynchronous reset between edges while in CAPTURE
        @(negedge clk);
        num_rows         = 8'd3;
        num_cols         = 8'd3;
        settle_counts    = 8'd2;
        frame_start      = 1'b1;
        adc_capture_done = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        seen        = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (adc_capture_start && col != 8'd0) begin
                seen = 1'b1;
            end else begin
                pixel_ack = pixel_req;
                @(negedge clk);
            end
        end
        check_eq("rst_reach_capture", int'(seen), 1);
        pixel_ack        = 1'b0;
        adc_capture_done = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_busy", int'(busy), 0);
        check_eq("async_cap", int'(adc_capture_start), 0);
        check_eq("async_col", int'(col), 0);
        check_eq("async_req", int'(pixel_req), 0);
        check_eq("async_flags", int'({newline_sample, frame_done}), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check_eq("post_rst_idle", int'(busy), 0);
        check_eq("post_rst_req", int'(pixel_req), 0);
        run_frame(1, 2, 1, 0, 1, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_scan_sequencer.md
# pixel_scan_sequencer

Frame-level scheduler for the Stonyman imaging path. On a frame request it walks a programmable rows × cols window pixel by pixel. For each pixel it asks the Stonyman pixel-select logic to address the pixel, waits a programmable analog settle time, fires one capture on the ADC controller and waits for its sample-complete strobe. It also produces the per-line and per-frame framing strobes used by the FIFO consumer and the pupil-detect line buffer.

## Interface
- MAX_DIM, 112: largest legal row/column count; sets the counter width to clog2(MAX_DIM).
- clk  in  1  system clock (40 MHz domain shared with the ADC controller).
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- frame_start  in  1  single-cycle request to scan one frame. Ignored unless the block is in IDLE.
- frame_abort  in  1  synchronous abort. Returns the block to IDLE on the next edge and suppresses frame_done.
- num_rows  in  8  rows per frame. Sampled at frame_start. A value of 0, or a value above MAX_DIM, is replaced by MAX_DIM.
- num_cols  in  8  columns per row. Same sampling and clamp rule as num_rows.
- settle_counts  in  8  cycles to wait after pixel_ack before capture. Sampled at frame_start. 0 means no wait.
- pixel_ack  in  1  pixel-select logic has addressed the pixel held on row/col.
- adc_capture_done  in  1  ADC controller strobe: the sample-and-hold is complete, so the next pixel may be addressed.
- pixel_req  out  1  level signal, held high until pixel_ack.
- row  out  8  current row index, 0-based.
- col  out  8  current column index, 0-based.
- adc_capture_start  out  1  one-cycle capture pulse to the ADC controller.
- newline_sample  out  1  one-cycle pulse marking the first capture of each row.
- frame_done  out  1  one-cycle pulse after the last pixel's adc_capture_done.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: waiting for a frame request.
  - SELECT: pixel_req=1; waiting for pixel_ack.
  - SETTLE: counting down the settle time.
  - CAPTURE: adc_capture_start pulses for exactly one cycle on entry, then the block waits for adc_capture_done.
  - ADVANCE: steps the pixel indices.
  - DONE: emits frame_done.
- IDLE → SELECT on frame_start. On this edge: latch the clamped num_rows/num_cols and settle_counts; set row=0, col=0.
- SELECT → SETTLE on pixel_ack, loading the settle counter with settle_counts. If settle_counts=0, go SELECT → CAPTURE directly.
- SETTLE: decrement the counter each cycle. Move to CAPTURE on the cycle the counter reaches 1. The block spends exactly settle_counts cycles in SETTLE.
- CAPTURE → ADVANCE on adc_capture_done. If adc_capture_done arrives in the same cycle as the start pulse, it is ignored; only later cycles count.
- ADVANCE:
  - If col < cols−1: col+1, then SELECT.
  - Else if row < rows−1: col=0, row+1, then SELECT.
  - Else: DONE.
- DONE → IDLE after one cycle with frame_done=1.
- newline_sample is asserted together with adc_capture_start whenever col==0.
- frame_abort has priority over every transition in every state. Its effects on the next edge:
  - state=IDLE, pixel_req=0, row=col=0.
  - No adc_capture_start, newline_sample or frame_done.
  - An ADC conversion already in flight is left to finish; the block does not wait for it.
- frame_start while busy: ignored, not queued.
- frame_start and frame_abort in the same cycle: abort wins; the block stays IDLE.
- Index arithmetic: 8-bit unsigned. Clamping guarantees cols−1 and rows−1 never underflow and the indices never wrap.

## Timing
- All outputs are registered.
- Reset values: all outputs 0 (pixel_req, row, col, adc_capture_start, newline_sample, frame_done, busy); state=IDLE.
- busy rises on the edge that samples frame_start. It falls on the edge that leaves DONE or that takes an abort.
- pixel_req:
  - Rises in the cycle after entering SELECT.
  - Falls in the cycle after pixel_ack is sampled.
  - pixel_ack asserted while pixel_req=0 is ignored.
- Per-pixel cycle count, with zero handshake wait: 1 (SELECT with immediate ack) + settle_counts + 1 (CAPTURE) + ADC done latency + 1 (ADVANCE).
- frame_done is asserted exactly 2 cycles after the final adc_capture_done is sampled (ADVANCE, then DONE).
- adc_capture_start never pulses more than once per pixel.

## Test plan
- Nominal 2×3 frame, settle_counts=4, ack 1 cycle after req, done 10 cycles after start:
  - 6 capture pulses, visiting (r,c) in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - newline_sample on the (0,0) and (1,0) captures only.
  - One frame_done, 2 cycles after the 6th done.
- settle_counts=0 with num_rows=num_cols=0 (clamped to 112): 12544 captures, then one frame_done; row/col never exceed 111.
- frame_abort in SETTLE at pixel (0,5) of a 4×8 frame:
  - busy=0 and pixel_req=0 on the next edge; row=col=0.
  - No further capture pulses and no frame_done.
  - A new frame_start then restarts at (0,0).
- frame_start pulsed repeatedly during a 1×2 frame: exactly 2 captures and one frame_done. A frame_start in the cycle after frame_done starts a fresh frame.
- adc_capture_done held high continuously: each pixel still gets exactly one adc_capture_start, and the done in the capture cycle itself does not advance the scan.
- Asynchronous reset asserted mid-CAPTURE, between clock edges: all outputs are 0 immediately, with no clock needed; after deassertion the block waits in IDLE for frame_start.
